network_result_collector: RTL and testbench

Downstream stage of the neural-network core: captures each output vector the network presents with its one-cycle valid strobe and optionally resolves the winning class by a sequential arg-max. Queues the results in a small FIFO so software can read them through the CSR block at its own pace. Sits between the network's output (values plus valid) and the CSR hardware-interface inputs inside the network top level.

---
 rtl/network_result_collector_pkg.sv | 36 +++
 rtl/network_result_collector_result_fifo.sv | 73 +++++++
 rtl/network_result_collector.sv | 212 +++++++++++++++++++++
 tb/tb_network_result_collector.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_result_collector_pkg.sv
// Shared types for the network result collector: entry layout, FSM states, width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef NUM_OL_NODES
`define NUM_OL_NODES 4
`endif
`ifndef FIXED_POINT_WORD_WIDTH
`define FIXED_POINT_WORD_WIDTH 8
`endif

package cortez_result_pkg;

    localparam int DEF_NUM_OL_NODES = `NUM_OL_NODES;
    localparam int DEF_WORD_WIDTH   = `FIXED_POINT_WORD_WIDTH;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Class index width; a single-node layer still gets one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CLASS_W = clog2_min1(DEF_NUM_OL_NODES);
    localparam int LEVEL_W = $clog2(DEF_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_NUM_OL_NODES*DEF_WORD_WIDTH-1:0] values;
        logic [CLASS_W-1:0]                         class_idx;
    } result_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        PUSH = 2'd2
    } state_t;

endpackage

// File: rtl/network_result_collector_result_fifo.sv
// Synchronous FIFO of result entries with clear, level and a head read straight from storage.
// Latency: a push is visible at the head/level one cycle later; pop takes effect at the next edge.
// Backpressure: push while full is refused unless a pop happens the same cycle; pop while empty is ignored.
//
// Ports: CLK/RSTN clock and async active-low reset; i_push/i_wr_entry write; i_pop discard head;
//        i_clear flush (wins over push/pop); o_head current head; o_full/o_empty/o_level status.
module result_fifo
    import cortez_result_pkg::*;
#(
    parameter type entry_t = result_entry_t,
    parameter int  DEPTH   = DEF_FIFO_DEPTH,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  entry_t        i_wr_entry,
    output entry_t        o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop at full frees the slot the simultaneous push lands in.
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wr_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_count;

endmodule

// File: rtl/network_result_collector.sv
// Captures network output vectors, optionally resolves the arg-max class, queues results for CSR reads.
// Latency: VALID_IN at t -> entry visible at t+NUM_OL_NODES+1 (arg-max) or t+2 (no arg-max).
// Backpressure: none upstream; vectors arriving while busy, or results hitting a full queue, are dropped and flagged sticky.
//
// Optional feature macro: CORTEZ_RESULT_ARGMAX_EN (defined: sequential arg-max; undefined: class tied to 0).
// Ports: CLK, RSTN (async active-low); VALUES_IN/VALID_IN network output; POP_IN/CLEAR_IN CSR pulses;
//        RESULT_VALUES_OUT/RESULT_CLASS_OUT/RESULT_VALID_OUT queue head; FIFO_LEVEL_OUT, BUSY_OUT, OVERFLOW_OUT status.
`ifndef NUM_OL_NODES
`define NUM_OL_NODES 4
`endif
`ifndef FIXED_POINT_WORD_WIDTH
`define FIXED_POINT_WORD_WIDTH 8
`endif

module network_result_collector
    import cortez_result_pkg::*;
#(
    parameter int  NUM_OL_NODES = `NUM_OL_NODES,
    parameter int  WORD_WIDTH   = `FIXED_POINT_WORD_WIDTH,
    parameter int  FIFO_DEPTH   = DEF_FIFO_DEPTH,
    localparam int VW           = NUM_OL_NODES * WORD_WIDTH,
    localparam int CW           = clog2_min1(NUM_OL_NODES),
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic signed [VW-1:0] VALUES_IN,
    input  logic                 VALID_IN,
    input  logic                 POP_IN,
    input  logic                 CLEAR_IN,
    output logic signed [VW-1:0] RESULT_VALUES_OUT,
    output logic        [CW-1:0] RESULT_CLASS_OUT,
    output logic                 RESULT_VALID_OUT,
    output logic        [LW-1:0] FIFO_LEVEL_OUT,
    output logic                 BUSY_OUT,
    output logic                 OVERFLOW_OUT
);

`ifdef CORTEZ_RESULT_ARGMAX_EN
    typedef struct packed {
        logic [VW-1:0] values;
        logic [CW-1:0] class_idx;
    } coll_entry_t;
`else
    // Without arg-max no class bits are stored at all.
    typedef struct packed {
        logic [VW-1:0] values;
    } coll_entry_t;
`endif

    state_t        r_state;
    state_t        w_next_state;
    logic [VW-1:0] r_capture;
    logic          r_overflow;
    logic          w_accept;
    logic          w_push;
    logic          w_busy;
    logic          w_full;
    logic          w_empty;
    logic          w_drop_vec;
    logic          w_drop_push;
    coll_entry_t   w_wr_entry;
    coll_entry_t   w_head;
    logic [LW-1:0] w_level;

`ifdef CORTEZ_RESULT_ARGMAX_EN
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OL_NODES - 1);

    logic        [CW-1:0]         r_idx;
    logic        [CW-1:0]         r_best_idx;
    logic signed [WORD_WIDTH-1:0] r_best_val;
    logic signed [WORD_WIDTH-1:0] w_scan_val;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        if (CLEAR_IN) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (VALID_IN) begin
`ifdef CORTEZ_RESULT_ARGMAX_EN
                        if (NUM_OL_NODES > 1) begin
                            w_next_state = SCAN;
                        end else begin
                            w_next_state = PUSH;
                        end
`else
                        w_next_state = PUSH;
`endif
                    end
                end
                SCAN: begin
`ifdef CORTEZ_RESULT_ARGMAX_EN
                    if (r_idx == LAST_IDX) begin
                        w_next_state = PUSH;
                    end
`else
                    w_next_state = IDLE;
`endif
                end
                PUSH:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_accept = (r_state == IDLE) & VALID_IN & ~CLEAR_IN;
        w_push   = (r_state == PUSH) & ~CLEAR_IN;
        w_busy   = (r_state != IDLE);
    end

    // ---------------- capture / arg-max datapath ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_capture <= '0;
        end else if (w_accept) begin
            r_capture <= VALUES_IN;
        end
    end

`ifdef CORTEZ_RESULT_ARGMAX_EN
    assign w_scan_val = r_capture[int'(r_idx)*WORD_WIDTH +: WORD_WIDTH];

    // Node 0 seeds the search on acceptance; SCAN walks nodes 1..N-1.
    // Strict compare keeps the lower index on ties.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else if (w_accept) begin
            r_idx      <= CW'(1);
            r_best_idx <= '0;
            r_best_val <= VALUES_IN[WORD_WIDTH-1:0];
        end else if (r_state == SCAN) begin
            if (w_scan_val > r_best_val) begin
                r_best_val <= w_scan_val;
                r_best_idx <= r_idx;
            end
            if (r_idx != LAST_IDX) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_wr_entry        = '0;
        w_wr_entry.values = r_capture;
`ifdef CORTEZ_RESULT_ARGMAX_EN
        w_wr_entry.class_idx = r_best_idx;
`endif
    end

    // ---------------- overflow ----------------
    // A pop at full always succeeds, so it always makes room for the push.
    assign w_drop_vec  = VALID_IN & w_busy;
    assign w_drop_push = w_push & w_full & ~POP_IN;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_overflow <= 1'b0;
        end else if (CLEAR_IN) begin
            r_overflow <= 1'b0;
        end else if (w_drop_vec | w_drop_push) begin
            r_overflow <= 1'b1;
        end
    end

    // ---------------- result queue ----------------
    result_fifo #(
        .entry_t (coll_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .i_push     (w_push),
        .i_pop      (POP_IN),
        .i_clear    (CLEAR_IN),
        .i_wr_entry (w_wr_entry),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    assign RESULT_VALUES_OUT = w_head.values;
`ifdef CORTEZ_RESULT_ARGMAX_EN
    assign RESULT_CLASS_OUT  = w_head.class_idx;
`else
    assign RESULT_CLASS_OUT  = '0;
`endif
    assign RESULT_VALID_OUT  = ~w_empty;
    assign FIFO_LEVEL_OUT    = w_level;
    assign BUSY_OUT          = w_busy;
    assign OVERFLOW_OUT      = r_overflow;

endmodule

// File: tb/tb_network_result_collector.sv
// Bench for network_result_collector: directed scenarios plus random traffic against a transaction-level model.
// Model: queue of expected results, sticky loss flag, and a busy window of fixed length per accepted vector.
// Adapts latency/class expectations to whether CORTEZ_RESULT_ARGMAX_EN is defined for the build.
module tb_network_result_collector;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 4;
`ifdef CORTEZ_RESULT_ARGMAX_EN
    localparam bit ARGMAX = 1'b1;
`else
    localparam bit ARGMAX = 1'b0;
`endif
    // Busy cycles per accepted vector; the last one is the queue write.
    localparam int LAT = ARGMAX ? N : 1;

    logic          CLK;
    logic          RSTN;
    logic [N*W-1:0] VALUES_IN;
    logic          VALID_IN;
    logic          POP_IN;
    logic          CLEAR_IN;
    logic [N*W-1:0] RESULT_VALUES_OUT;
    logic [1:0]    RESULT_CLASS_OUT;
    logic          RESULT_VALID_OUT;
    logic [2:0]    FIFO_LEVEL_OUT;
    logic          BUSY_OUT;
    logic          OVERFLOW_OUT;

    network_result_collector #(
        .NUM_OL_NODES (N),
        .WORD_WIDTH   (W),
        .FIFO_DEPTH   (D)
    ) dut (
        .CLK               (CLK),
        .RSTN              (RSTN),
        .VALUES_IN         (VALUES_IN),
        .VALID_IN          (VALID_IN),
        .POP_IN            (POP_IN),
        .CLEAR_IN          (CLEAR_IN),
        .RESULT_VALUES_OUT (RESULT_VALUES_OUT),
        .RESULT_CLASS_OUT  (RESULT_CLASS_OUT),
        .RESULT_VALID_OUT  (RESULT_VALID_OUT),
        .FIFO_LEVEL_OUT    (FIFO_LEVEL_OUT),
        .BUSY_OUT          (BUSY_OUT),
        .OVERFLOW_OUT      (OVERFLOW_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N*W-1:0] vals;
        int             cls;
    } exp_t;

    exp_t m_q[$];
    exp_t m_pend;
    bit   m_ovf;
    int   m_busy;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Winning class: first index holding the largest signed value.
    function automatic int ref_class(input logic [N*W-1:0] v);
        int best = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i*W +: W]) > $signed(v[best*W +: W])) best = i;
        end
        return ARGMAX ? best : 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_busy = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs currently driven.
    task automatic model_edge();
        int sz;
        bit do_pop;
        bit do_push;
        if (CLEAR_IN) begin
            model_reset();
            return;
        end
        sz      = m_q.size();
        do_pop  = POP_IN && (sz > 0);
        do_push = 1'b0;
        if (m_busy > 0) begin
            if (VALID_IN) m_ovf = 1'b1;
            if (m_busy == 1) begin
                if (sz < D || do_pop) do_push = 1'b1;
                else                  m_ovf   = 1'b1;
            end
            m_busy--;
        end else if (VALID_IN) begin
            m_pend.vals = VALUES_IN;
            m_pend.cls  = ref_class(VALUES_IN);
            m_busy      = LAT;
        end
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(m_pend);
    endtask

    task automatic compare_all();
        check_eq("valid", RESULT_VALID_OUT, m_q.size() != 0);
        check_eq("level", FIFO_LEVEL_OUT, m_q.size());
        check_eq("ovf",   OVERFLOW_OUT, m_ovf);
        check_eq("busy",  BUSY_OUT, m_busy > 0);
        if (m_q.size() > 0) begin
            check_eq("head_vals",  RESULT_VALUES_OUT, m_q[0].vals);
            check_eq("head_class", RESULT_CLASS_OUT, m_q[0].cls);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
        VALID_IN = 1'b0;
        POP_IN   = 1'b0;
        CLEAR_IN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [N*W-1:0] v);
        VALUES_IN = v;
        VALID_IN  = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] vs [5];
        logic [N*W-1:0] va;
        int gap;

        RSTN      = 1'b0;
        VALUES_IN = '0;
        VALID_IN  = 1'b0;
        POP_IN    = 1'b0;
        CLEAR_IN  = 1'b0;
        model_reset();
        #23;
        check_eq("rst_vals",  RESULT_VALUES_OUT, 0);
        check_eq("rst_class", RESULT_CLASS_OUT, 0);
        check_eq("rst_valid", RESULT_VALID_OUT, 0);
        check_eq("rst_level", FIFO_LEVEL_OUT, 0);
        check_eq("rst_busy",  BUSY_OUT, 0);
        check_eq("rst_ovf",   OVERFLOW_OUT, 0);
        RSTN = 1'b1;
        idle(2);

        // Basic capture and class resolution.
        va = pack4(5, -3, 12, 7);
        send(va);
        idle(LAT - 1);
        check_eq("t1_early_valid", RESULT_VALID_OUT, 0);
        idle(1);
        check_eq("t1_valid", RESULT_VALID_OUT, 1);
        check_eq("t1_vals",  RESULT_VALUES_OUT, va);
        check_eq("t1_class", RESULT_CLASS_OUT, ARGMAX ? 2 : 0);
        check_eq("t1_level", FIFO_LEVEL_OUT, 1);
        POP_IN = 1'b1;
        step();
        check_eq("t1_pop_level", FIFO_LEVEL_OUT, 0);

        // Tie keeps the lower index; all-negative vector.
        send(pack4(-8, 20, 20, -1));
        idle(LAT);
        check_eq("tie_class", RESULT_CLASS_OUT, ARGMAX ? 1 : 0);
        POP_IN = 1'b1;
        step();
        send(pack4(-9, -2, -5, -128));
        idle(LAT);
        check_eq("neg_class", RESULT_CLASS_OUT, ARGMAX ? 1 : 0);
        POP_IN = 1'b1;
        step();

        // Five results, no pops: fifth is lost, first stays at the head.
        for (int k = 0; k < 5; k++) begin
            vs[k] = {$urandom};
            send(vs[k]);
            idle(LAT + 1);
        end
        check_eq("fill_level", FIFO_LEVEL_OUT, 4);
        check_eq("fill_ovf",   OVERFLOW_OUT, 1);
        check_eq("fill_head",  RESULT_VALUES_OUT, vs[0]);
        for (int k = 0; k < 4; k++) begin
            check_eq("drain_order", RESULT_VALUES_OUT, vs[k]);
            POP_IN = 1'b1;
            step();
        end
        check_eq("drain_level", FIFO_LEVEL_OUT, 0);
        CLEAR_IN = 1'b1;
        step();
        check_eq("clr_ovf", OVERFLOW_OUT, 0);

        // Vector arriving while busy is dropped.
        gap = (LAT >= 2) ? 2 : 1;
        va  = pack4(1, 2, 3, 4);
        send(va);
        idle(gap - 1);
        send(pack4(9, 9, 9, 9));
        check_eq("busy_drop_ovf", OVERFLOW_OUT, 1);
        idle(LAT);
        check_eq("busy_drop_level", FIFO_LEVEL_OUT, 1);
        check_eq("busy_drop_head",  RESULT_VALUES_OUT, va);
        CLEAR_IN = 1'b1;
        step();
        check_eq("clear_level", FIFO_LEVEL_OUT, 0);
        check_eq("clear_ovf",   OVERFLOW_OUT, 0);
        check_eq("clear_busy",  BUSY_OUT, 0);

        // Clear mid-operation aborts the pending result.
        send(pack4(3, 1, 4, 1));
        CLEAR_IN = 1'b1;
        step();
        check_eq("abort_busy", BUSY_OUT, 0);
        idle(LAT + 1);
        check_eq("abort_level", FIFO_LEVEL_OUT, 0);

        // Full queue with a pop coinciding with the push.
        for (int k = 0; k < 4; k++) begin
            vs[k] = {$urandom};
            send(vs[k]);
            idle(LAT + 1);
        end
        vs[4] = {$urandom};
        send(vs[4]);
        idle(LAT - 1);
        POP_IN = 1'b1;
        step();
        check_eq("full_pop_level", FIFO_LEVEL_OUT, 4);
        check_eq("full_pop_ovf",   OVERFLOW_OUT, 0);
        check_eq("full_pop_head",  RESULT_VALUES_OUT, vs[1]);
        for (int k = 1; k < 5; k++) begin
            check_eq("full_pop_order", RESULT_VALUES_OUT, vs[k]);
            POP_IN = 1'b1;
            step();
        end
        POP_IN = 1'b1;
        step();
        check_eq("empty_pop_level", FIFO_LEVEL_OUT, 0);
        check_eq("empty_pop_ovf",   OVERFLOW_OUT, 0);
        check_eq("empty_pop_valid", RESULT_VALID_OUT, 0);

        // Reset in the middle of an operation: nothing gets pushed afterwards.
        send(pack4(7, 6, 5, 4));
        idle(1);
        #1 RSTN = 1'b0;
        #1;
        check_eq("mid_rst_busy",  BUSY_OUT, 0);
        check_eq("mid_rst_level", FIFO_LEVEL_OUT, 0);
        check_eq("mid_rst_ovf",   OVERFLOW_OUT, 0);
        model_reset();
        @(negedge CLK);
        RSTN = 1'b1;
        idle(LAT + 2);
        check_eq("mid_rst_nopush", FIFO_LEVEL_OUT, 0);

        // Random traffic; masking some vectors to a few values forces ties.
        for (int c = 0; c < 800; c++) begin
            VALID_IN = ($urandom_range(0, 2) == 0);
            VALUES_IN = {$urandom};
            if ($urandom_range(0, 1) == 1) VALUES_IN = VALUES_IN & 32'h8383_8383;
            POP_IN   = ($urandom_range(0, 3) == 0);
            CLEAR_IN = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
